// File: rtl/pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit
//
// Scoreboard-based hazard detection and operand forwarding for an in-order
// MIPS-style pipeline. The unit remembers, for DEPTH stages past ID, whether
// the instruction in that stage will write a register, which one, and whether
// it is a load. From that history it chooses the forwarding source for both
// ID source operands and raises a stall for load-use hazards (or for any RAW
// hazard when forwarding is disabled). A taken branch resolved in EX squashes
// the ID instruction.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   id_valid              ID holds a valid instruction
//   id_rs / id_rt         source register indices
//   id_rs_used/id_rt_used instruction actually reads rs / rt
//   id_rd, id_we, id_ld   destination index, writes-register flag, load flag
//   ex_btaken             branch/jump taken in EX this cycle
//   rf_rs / rf_rt         register file read data
//   res_bus               slot k-1 carries the result held in stage k
//   opa / opb             forwarded operands (combinational)
//   fwd_rs_sel/fwd_rt_sel 0 = register file, k = stage k
//   stall                 hold PC and IF/ID, bubble into EX
//   flush_id              discard the ID instruction
//   stall_cnt/flush_cnt   saturating event counters
//   dbg_sb_v              scoreboard valid bits, bit k-1 = entry k
//
// Stall/flush handshake: stall and flush_id are pure functions of the current
// scoreboard and ID/EX inputs in the same cycle. The scoreboard always
// advances; when stall or flush_id is high, a bubble (v=0) enters entry 1 and
// the surrounding pipeline is expected to hold IF/ID (stall) or drop the ID
// instruction (flush_id). flush_id wins over stall.
// -----------------------------------------------------------------------------
module pipe_hazard_unit #(
    parameter  int XLEN     = 32,
    parameter  int RIDX_W   = 5,
    parameter  int DEPTH    = 3,
    parameter  int LOAD_LAT = 3,
    parameter  int FWD_EN   = 1,
    parameter  int CNT_W    = 32,
    localparam int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [RIDX_W-1:0]       id_rs,
    input  logic [RIDX_W-1:0]       id_rt,
    input  logic                    id_rs_used,
    input  logic                    id_rt_used,
    input  logic [RIDX_W-1:0]       id_rd,
    input  logic                    id_we,
    input  logic                    id_ld,
    input  logic                    ex_btaken,
    input  logic [XLEN-1:0]         rf_rs,
    input  logic [XLEN-1:0]         rf_rt,
    input  logic [DEPTH*XLEN-1:0]   res_bus,
    output logic [XLEN-1:0]         opa,
    output logic [XLEN-1:0]         opb,
    output logic [SEL_W-1:0]        fwd_rs_sel,
    output logic [SEL_W-1:0]        fwd_rt_sel,
    output logic                    stall,
    output logic                    flush_id,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt,
    output logic [DEPTH-1:0]        dbg_sb_v
);

    localparam logic [SEL_W-1:0] LL_K    = SEL_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Scoreboard: entry k describes the instruction k stages past ID.
    logic              r_v  [1:DEPTH];
    logic [RIDX_W-1:0] r_rd [1:DEPTH];
    logic              r_ld [1:DEPTH];

    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    // Youngest-match lookup results.
    logic              w_rs_hit;
    logic              w_rs_ld;
    logic [SEL_W-1:0]  w_rs_k;
    logic              w_rt_hit;
    logic              w_rt_ld;
    logic [SEL_W-1:0]  w_rt_k;

    // Hazard resolution.
    logic              w_rs_hz;
    logic              w_rt_hz;
    logic [SEL_W-1:0]  w_rs_sel;
    logic [SEL_W-1:0]  w_rt_sel;
    logic              w_stall;
    logic              w_flush;
    logic              w_ent1_v;

    // -------------------------------------------------------------------------
    // Youngest matching writer. The loop walks from the oldest entry to the
    // youngest so the last hit (smallest k) is the one that remains.
    // Register 0 is never tracked as a dependency.
    // -------------------------------------------------------------------------
    always_comb begin
        w_rs_hit = 1'b0;
        w_rs_ld  = 1'b0;
        w_rs_k   = '0;
        w_rt_hit = 1'b0;
        w_rt_ld  = 1'b0;
        w_rt_k   = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (r_v[k] && (r_rd[k] == id_rs) && id_rs_used && (id_rs != '0)) begin
                w_rs_hit = 1'b1;
                w_rs_ld  = r_ld[k];
                w_rs_k   = SEL_W'(k);
            end
            if (r_v[k] && (r_rd[k] == id_rt) && id_rt_used && (id_rt != '0)) begin
                w_rt_hit = 1'b1;
                w_rt_ld  = r_ld[k];
                w_rt_k   = SEL_W'(k);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-operand hazard / select. With forwarding, only a load that has not
    // yet reached LOAD_LAT blocks; its select is forced to 0 while blocked.
    // Without forwarding, any pending writer blocks until it leaves stage
    // DEPTH, at which point the register file holds the value.
    // -------------------------------------------------------------------------
    always_comb begin
        w_rs_hz  = 1'b0;
        w_rs_sel = '0;
        if (w_rs_hit) begin
            if (FWD_EN == 0) begin
                w_rs_hz = 1'b1;
            end else if (w_rs_ld && (w_rs_k < LL_K)) begin
                w_rs_hz = 1'b1;
            end else begin
                w_rs_sel = w_rs_k;
            end
        end
    end

    always_comb begin
        w_rt_hz  = 1'b0;
        w_rt_sel = '0;
        if (w_rt_hit) begin
            if (FWD_EN == 0) begin
                w_rt_hz = 1'b1;
            end else if (w_rt_ld && (w_rt_k < LL_K)) begin
                w_rt_hz = 1'b1;
            end else begin
                w_rt_sel = w_rt_k;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Operand muxes: select 0 is the register file, k is res_bus slot k-1.
    // -------------------------------------------------------------------------
    always_comb begin
        opa = rf_rs;
        opb = rf_rt;
        for (int k = 1; k <= DEPTH; k++) begin
            if (w_rs_sel == SEL_W'(k)) begin
                opa = res_bus[(k-1)*XLEN +: XLEN];
            end
            if (w_rt_sel == SEL_W'(k)) begin
                opb = res_bus[(k-1)*XLEN +: XLEN];
            end
        end
    end

    // A taken branch kills the ID instruction, so it must not also stall.
    assign w_stall  = id_valid & (w_rs_hz | w_rt_hz) & ~ex_btaken;
    assign w_flush  = ex_btaken & id_valid;

    // Stalled or flushed instructions enter the scoreboard as bubbles.
    assign w_ent1_v = id_valid & id_we & (id_rd != '0) & ~w_stall & ~ex_btaken;

    // -------------------------------------------------------------------------
    // Scoreboard shift register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_v[k]  <= 1'b0;
                r_rd[k] <= '0;
                r_ld[k] <= 1'b0;
            end
        end else begin
            r_v[1]  <= w_ent1_v;
            r_rd[1] <= id_rd;
            r_ld[1] <= id_ld;
            for (int k = 2; k <= DEPTH; k++) begin
                r_v[k]  <= r_v[k-1];
                r_rd[k] <= r_rd[k-1];
                r_ld[k] <= r_ld[k-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Saturating performance counters.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        dbg_sb_v = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            dbg_sb_v[k-1] = r_v[k];
        end
    end

    assign fwd_rs_sel = w_rs_sel;
    assign fwd_rt_sel = w_rt_sel;
    assign stall      = w_stall;
    assign flush_id   = w_flush;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// Bench for pipe_hazard_unit. Three instances with independent stimulus:
//   u0: FWD_EN=1, LOAD_LAT=3, CNT_W=32
//   u1: FWD_EN=0, LOAD_LAT=3, CNT_W=32
//   u2: FWD_EN=1, LOAD_LAT=3, CNT_W=4
// The reference keeps a history queue of issued instructions per instance and
// derives forwarding/stall decisions from it every cycle.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_unit;

    localparam int NU    = 3;
    localparam int DEPTH = 3;
    localparam int LL    = 3;
    localparam int FWD_P [NU] = '{1, 0, 1};
    localparam int CW_P  [NU] = '{32, 32, 4};

    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } ent_t;

    typedef struct {
        logic        stall;
        logic        flush;
        int          sa;
        int          sb;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic        id_valid   [NU];
    logic [4:0]  id_rs      [NU];
    logic [4:0]  id_rt      [NU];
    logic        id_rs_used [NU];
    logic        id_rt_used [NU];
    logic [4:0]  id_rd      [NU];
    logic        id_we      [NU];
    logic        id_ld      [NU];
    logic        ex_btaken  [NU];
    logic [31:0] rf_rs      [NU];
    logic [31:0] rf_rt      [NU];
    logic [95:0] res_bus    [NU];

    wire [NU-1:0]       o_stall;
    wire [NU-1:0]       o_flush;
    wire [NU-1:0][1:0]  o_sel_rs;
    wire [NU-1:0][1:0]  o_sel_rt;
    wire [NU-1:0][31:0] o_opa;
    wire [NU-1:0][31:0] o_opb;
    wire [NU-1:0][31:0] o_scnt;
    wire [NU-1:0][31:0] o_fcnt;
    wire [NU-1:0][2:0]  o_dbg;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        wire [CW_P[g]-1:0] l_scnt;
        wire [CW_P[g]-1:0] l_fcnt;
        pipe_hazard_unit #(
            .XLEN     (32),
            .RIDX_W   (5),
            .DEPTH    (DEPTH),
            .LOAD_LAT (LL),
            .FWD_EN   (FWD_P[g]),
            .CNT_W    (CW_P[g])
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .id_valid   (id_valid[g]),
            .id_rs      (id_rs[g]),
            .id_rt      (id_rt[g]),
            .id_rs_used (id_rs_used[g]),
            .id_rt_used (id_rt_used[g]),
            .id_rd      (id_rd[g]),
            .id_we      (id_we[g]),
            .id_ld      (id_ld[g]),
            .ex_btaken  (ex_btaken[g]),
            .rf_rs      (rf_rs[g]),
            .rf_rt      (rf_rt[g]),
            .res_bus    (res_bus[g]),
            .opa        (o_opa[g]),
            .opb        (o_opb[g]),
            .fwd_rs_sel (o_sel_rs[g]),
            .fwd_rt_sel (o_sel_rt[g]),
            .stall      (o_stall[g]),
            .flush_id   (o_flush[g]),
            .stall_cnt  (l_scnt),
            .flush_cnt  (l_fcnt),
            .dbg_sb_v   (o_dbg[g])
        );
        assign o_scnt[g] = 32'(l_scnt);
        assign o_fcnt[g] = 32'(l_fcnt);
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t   hist   [NU][$];   // hist[u][k-1] = instruction k stages past ID
    longint m_scnt [NU];
    longint m_fcnt [NU];

    function automatic longint cmax(input int u);
        return (longint'(1) << CW_P[u]) - 1;
    endfunction

    function automatic int youngest(input int u, input logic [4:0] r, input logic used);
        if (!used || r == 5'd0) return 0;
        for (int k = 1; k <= hist[u].size(); k++) begin
            if (hist[u][k-1].v && hist[u][k-1].rd == r) return k;
        end
        return 0;
    endfunction

    function automatic exp_t eval(input int u);
        exp_t e;
        int   ka;
        int   kb;
        logic ha;
        logic hb;
        ka = youngest(u, id_rs[u], id_rs_used[u]);
        kb = youngest(u, id_rt[u], id_rt_used[u]);
        ha = 1'b0;
        hb = 1'b0;
        e.sa = 0;
        e.sb = 0;
        if (ka != 0) begin
            if (FWD_P[u] == 0 || (hist[u][ka-1].ld && ka < LL)) ha = 1'b1;
            else e.sa = ka;
        end
        if (kb != 0) begin
            if (FWD_P[u] == 0 || (hist[u][kb-1].ld && kb < LL)) hb = 1'b1;
            else e.sb = kb;
        end
        e.stall = id_valid[u] && (ha || hb) && !ex_btaken[u];
        e.flush = ex_btaken[u] && id_valid[u];
        e.a = (e.sa == 0) ? rf_rs[u] : res_bus[u][(e.sa-1)*32 +: 32];
        e.b = (e.sb == 0) ? rf_rt[u] : res_bus[u][(e.sb-1)*32 +: 32];
        return e;
    endfunction

    function automatic logic [2:0] exp_dbg(input int u);
        logic [2:0] d;
        d = 3'b000;
        for (int k = 1; k <= hist[u].size(); k++) d[k-1] = hist[u][k-1].v;
        return d;
    endfunction

    task automatic model_clear();
        for (int u = 0; u < NU; u++) begin
            hist[u].delete();
            m_scnt[u] = 0;
            m_fcnt[u] = 0;
        end
    endtask

    // Model advance: sample inputs at the active edge, clear on reset.
    initial begin
        exp_t e;
        ent_t n;
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_clear();
            end else begin
                for (int u = 0; u < NU; u++) begin
                    e = eval(u);
                    if (e.stall && m_scnt[u] < cmax(u)) m_scnt[u]++;
                    if (e.flush && m_fcnt[u] < cmax(u)) m_fcnt[u]++;
                    n.v  = id_valid[u] && id_we[u] && (id_rd[u] != 5'd0) && !e.stall && !ex_btaken[u];
                    n.rd = id_rd[u];
                    n.ld = id_ld[u];
                    hist[u].push_front(n);
                    if (hist[u].size() > DEPTH) void'(hist[u].pop_back());
                end
            end
        end
    end

    // Compare process: every falling edge, all instances.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                e = eval(u);
                chk($sformatf("u%0d.stall", u),    64'(o_stall[u]),  64'(e.stall));
                chk($sformatf("u%0d.flush_id", u), 64'(o_flush[u]),  64'(e.flush));
                chk($sformatf("u%0d.rs_sel", u),   64'(o_sel_rs[u]), 64'(e.sa));
                chk($sformatf("u%0d.rt_sel", u),   64'(o_sel_rt[u]), 64'(e.sb));
                chk($sformatf("u%0d.opa", u),      64'(o_opa[u]),    64'(e.a));
                chk($sformatf("u%0d.opb", u),      64'(o_opb[u]),    64'(e.b));
                chk($sformatf("u%0d.stall_cnt", u), 64'(o_scnt[u]),  64'(m_scnt[u]));
                chk($sformatf("u%0d.flush_cnt", u), 64'(o_fcnt[u]),  64'(m_fcnt[u]));
                chk($sformatf("u%0d.sb_v", u),     64'(o_dbg[u]),    64'(exp_dbg(u)));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int u);
        id_valid[u]   = 1'b0;
        id_rs[u]      = 5'd0;
        id_rt[u]      = 5'd0;
        id_rs_used[u] = 1'b0;
        id_rt_used[u] = 1'b0;
        id_rd[u]      = 5'd0;
        id_we[u]      = 1'b0;
        id_ld[u]      = 1'b0;
        ex_btaken[u]  = 1'b0;
        rf_rs[u]      = 32'h1111_0000;
        rf_rt[u]      = 32'h2222_0000;
        res_bus[u]    = {32'h0000_00C3, 32'h0000_00C2, 32'h0000_00C1};
    endtask

    task automatic wr(input int u, input logic [4:0] rd, input logic ld);
        idle(u);
        id_valid[u] = 1'b1;
        id_rd[u]    = rd;
        id_we[u]    = 1'b1;
        id_ld[u]    = ld;
    endtask

    task automatic rdr(input int u, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu);
        idle(u);
        id_valid[u]   = 1'b1;
        id_rs[u]      = rs;
        id_rt[u]      = rt;
        id_rs_used[u] = rsu;
        id_rt_used[u] = rtu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int u);
        idle(u);
        repeat (4) tick();
    endtask

    // Watchdog: the directed sequence is short; this only fires on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        for (int u = 0; u < NU; u++) idle(u);
        #1 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst.stall",     64'(o_stall[0]),  64'd0);
        chk("rst.stall_cnt", 64'(o_scnt[0]),   64'd0);
        chk("rst.sb_v",      64'(o_dbg[0]),    64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: ALU result forwarded from EX
        drain(0);
        wr(0, 5'd3, 1'b0);
        tick();
        rdr(0, 5'd3, 5'd0, 1'b1, 1'b0);
        res_bus[0][31:0] = 32'h11;
        @(negedge clk);
        chk("t1.rs_sel", 64'(o_sel_rs[0]), 64'd1);
        chk("t1.opa",    64'(o_opa[0]),    64'h11);
        chk("t1.stall",  64'(o_stall[0]),  64'd0);

        // 2: load-use, two stall cycles, then forward from stage 3
        drain(0);
        wr(0, 5'd4, 1'b1);
        tick();
        rdr(0, 5'd4, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t2.stall_c1", 64'(o_stall[0]), 64'd1);
        chk("t2.sel_c1",   64'(o_sel_rs[0]), 64'd0);
        tick();
        @(negedge clk);
        chk("t2.stall_c2", 64'(o_stall[0]), 64'd1);
        tick();
        res_bus[0][95:64] = 32'h44;
        @(negedge clk);
        chk("t2.stall_c3", 64'(o_stall[0]), 64'd0);
        chk("t2.rs_sel",   64'(o_sel_rs[0]), 64'd3);
        chk("t2.opa",      64'(o_opa[0]),    64'h44);
        chk("t2.stall_cnt", 64'(o_scnt[0]),  64'd2);
        chk("t2.sb_v",     64'(o_dbg[0]),    64'b100);

        // 3: two writers to $5, youngest wins
        drain(0);
        wr(0, 5'd5, 1'b0);
        tick();
        wr(0, 5'd5, 1'b0);
        tick();
        rdr(0, 5'd0, 5'd5, 1'b0, 1'b1);
        res_bus[0] = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
        @(negedge clk);
        chk("t3.rt_sel", 64'(o_sel_rt[0]), 64'd1);
        chk("t3.opb",    64'(o_opb[0]),    64'hA);
        chk("t3.sb_v",   64'(o_dbg[0]),    64'b011);

        // 4: writes to $0 are never tracked
        drain(0);
        wr(0, 5'd0, 1'b0);
        tick();
        rdr(0, 5'd0, 5'd0, 1'b1, 1'b0);
        rf_rs[0] = 32'h0;
        @(negedge clk);
        chk("t4.rs_sel", 64'(o_sel_rs[0]), 64'd0);
        chk("t4.opa",    64'(o_opa[0]),    64'd0);
        chk("t4.stall",  64'(o_stall[0]),  64'd0);
        chk("t4.sb_v",   64'(o_dbg[0]),    64'd0);

        // 5: taken branch during a load-use stall
        drain(0);
        wr(0, 5'd7, 1'b1);
        tick();
        rdr(0, 5'd7, 5'd0, 1'b1, 1'b0);
        id_we[0] = 1'b1;
        id_rd[0] = 5'd10;
        @(negedge clk);
        chk("t5.stall_pre", 64'(o_stall[0]), 64'd1);
        tick();
        ex_btaken[0] = 1'b1;
        @(negedge clk);
        chk("t5.stall", 64'(o_stall[0]), 64'd0);
        chk("t5.flush", 64'(o_flush[0]), 64'd1);
        tick();
        idle(0);
        @(negedge clk);
        chk("t5.sb_v",      64'(o_dbg[0]),  64'b100);
        chk("t5.flush_cnt", 64'(o_fcnt[0]), 64'd1);
        chk("t5.stall_cnt", 64'(o_scnt[0]), 64'd3);

        // 6a: no forwarding, ALU writer blocks for DEPTH cycles
        drain(1);
        wr(1, 5'd6, 1'b0);
        tick();
        rdr(1, 5'd6, 5'd0, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_stall[1]) begin
                n++;
                tick();
            end else begin
                break;
            end
        end
        chk("t6a.stall_cycles", 64'(n), 64'd3);
        chk("t6a.rs_sel",       64'(o_sel_rs[1]), 64'd0);
        chk("t6a.opa",          64'(o_opa[1]),    64'h1111_0000);
        tick();
        idle(1);

        // 6b: asynchronous reset in mid-stall
        drain(0);
        wr(0, 5'd8, 1'b1);
        tick();
        rdr(0, 5'd8, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t6b.stall_pre", 64'(o_stall[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6b.stall",      64'(o_stall[0]),  64'd0);
        chk("t6b.rs_sel",     64'(o_sel_rs[0]), 64'd0);
        chk("t6b.stall_cnt",  64'(o_scnt[0]),   64'd0);
        chk("t6b.flush_cnt",  64'(o_fcnt[0]),   64'd0);
        chk("t6b.u1_scnt",    64'(o_scnt[1]),   64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(0);

        // 6c: 4-bit counter saturates at 15
        drain(2);
        for (int it = 0; it < 10; it++) begin
            wr(2, 5'd9, 1'b1);
            tick();
            rdr(2, 5'd9, 5'd0, 1'b1, 1'b0);
            tick();
            tick();
            if (it == 6) begin
                @(negedge clk);
                chk("t6c.cnt14", 64'(o_scnt[2]), 64'd14);
                tick();
            end
        end
        drain(2);
        @(negedge clk);
        chk("t6c.cnt_sat", 64'(o_scnt[2]), 64'd15);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
